sha256d_nonce_scheduler: RTL and testbench

//  Sequences the Hasher for double-SHA256 mining over a nonce range, one nonce at a time.
//  Per nonce: issues header blocks 1 and 2, then issues the padded first digest as block 3.

---
 rtl/sha256d_nonce_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_sha256d_nonce_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256d_nonce_scheduler.sv
// Double-SHA256 nonce sequencer: feeds header/nonce blocks and the padded first digest to a
// block-oriented Hasher, then compares each final digest against the job target.
module sha256d_nonce_scheduler #(
    parameter logic [31:0] NONCE_STEP     = 32'd1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] header,
    input  logic [255:0] target,
    input  logic [31:0]  nonceStart,
    input  logic [31:0]  nonceEnd,
    output logic         blkValid,
    input  logic         blkReady,
    output logic         blkFirst,
    output logic         blkLast,
    output logic [511:0] blkData,
    input  logic         hashValid,
    output logic         hashReady,
    input  logic [255:0] hash,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  foundNonce,
    output logic [255:0] foundHash,
    output logic [31:0]  hashCount,
    output logic         timeoutErr
);
    typedef enum logic [3:0] {
        IDLE, SEND1, SEND2, WAIT1, SEND3, WAIT2, CHECK, FINISH, DRAIN
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [607:0]  header_reg, header_next;     // header words 0..18; the nonce word is ours
    logic [255:0]  target_reg, target_next;
    logic [31:0]   nonce_reg, nonce_next;
    logic [31:0]   nonce_end_reg, nonce_end_next;
    logic [255:0]  h1_reg, h1_next;
    logic [255:0]  h2_reg, h2_next;
    logic          found_reg, found_next;
    logic [31:0]   found_nonce_reg, found_nonce_next;
    logic [255:0]  found_hash_reg, found_hash_next;
    logic [31:0]   hash_count_reg, hash_count_next;
    logic          timeout_err_reg, timeout_err_next;
    logic [31:0]   tmo_cnt_reg, tmo_cnt_next;

    logic          blk_xfer, hash_xfer, tmo_hit, range_end;
    logic [32:0]   nonce_sum;
    logic          unused_nonce_word;

    assign unused_nonce_word = ^header[31:0];

    assign blk_xfer  = blkValid & blkReady;
    assign hash_xfer = hashValid & hashReady;
    assign tmo_hit   = (tmo_cnt_reg == TMO_LAST);
    // 33-bit sum so a step past 0xFFFFFFFF ends the job instead of wrapping to 0
    assign nonce_sum = {1'b0, nonce_reg} + {1'b0, NONCE_STEP};
    assign range_end = nonce_sum[32] || (nonce_sum[31:0] > nonce_end_reg);

    always_comb begin
        state_next       = state_reg;
        header_next      = header_reg;
        target_next      = target_reg;
        nonce_next       = nonce_reg;
        nonce_end_next   = nonce_end_reg;
        h1_next          = h1_reg;
        h2_next          = h2_reg;
        found_next       = found_reg;
        found_nonce_next = found_nonce_reg;
        found_hash_next  = found_hash_reg;
        hash_count_next  = hash_count_reg;
        timeout_err_next = timeout_err_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next       = SEND1;
                    header_next      = header[639:32];
                    target_next      = target;
                    nonce_next       = nonceStart;
                    nonce_end_next   = nonceEnd;
                    found_next       = 1'b0;
                    found_nonce_next = '0;
                    found_hash_next  = '0;
                    hash_count_next  = '0;
                    timeout_err_next = 1'b0;
                end
            end
            SEND1: begin
                if (abort) begin
                    state_next = FINISH;
                end else if (blk_xfer) begin
                    state_next = SEND2;
                end else if (tmo_hit) begin
                    state_next       = FINISH;
                    timeout_err_next = 1'b1;
                end
            end
            SEND2, SEND3: begin
                // a last block that transfers alongside abort still owes us a digest
                if (abort) begin
                    state_next = blk_xfer ? DRAIN : FINISH;
                end else if (blk_xfer) begin
                    state_next = (state_reg == SEND2) ? WAIT1 : WAIT2;
                end else if (tmo_hit) begin
                    state_next       = FINISH;
                    timeout_err_next = 1'b1;
                end
            end
            WAIT1, WAIT2: begin
                if (hash_xfer) begin
                    if (state_reg == WAIT1) h1_next = hash;
                    else                    h2_next = hash;
                end
                if (abort) begin
                    state_next = hash_xfer ? FINISH : DRAIN;
                end else if (hash_xfer) begin
                    state_next = (state_reg == WAIT1) ? SEND3 : CHECK;
                end else if (tmo_hit) begin
                    state_next       = FINISH;
                    timeout_err_next = 1'b1;
                end
            end
            CHECK: begin
                if (hash_count_reg != '1) hash_count_next = hash_count_reg + 32'd1;
                if (abort) begin
                    state_next = FINISH;
                end else if (h2_reg <= target_reg) begin
                    state_next       = FINISH;
                    found_next       = 1'b1;
                    found_nonce_next = nonce_reg;
                    found_hash_next  = h2_reg;
                end else if (range_end) begin
                    state_next = FINISH;
                end else begin
                    state_next = SEND1;
                    nonce_next = nonce_sum[31:0];
                end
            end
            DRAIN: begin
                if (hash_xfer) begin
                    state_next = FINISH;
                end else if (tmo_hit) begin
                    state_next       = FINISH;
                    timeout_err_next = 1'b1;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        tmo_cnt_next = (state_next != state_reg) ? '0 : tmo_cnt_reg + 32'd1;
    end

    always_comb begin
        blkValid  = (state_reg == SEND1) || (state_reg == SEND2) || (state_reg == SEND3);
        blkFirst  = (state_reg == SEND1) || (state_reg == SEND3);
        blkLast   = (state_reg == SEND2) || (state_reg == SEND3);
        hashReady = (state_reg == WAIT1) || (state_reg == WAIT2) || (state_reg == DRAIN);
        busy      = (state_reg != IDLE);
        done      = (state_reg == FINISH);
        blkData   = '0;
        case (state_reg)
            SEND1:   blkData = header_reg[607:96];
            SEND2:   blkData = {header_reg[95:0], nonce_reg, 32'h80000000, 320'd0, 32'h00000280};
            SEND3:   blkData = {h1_reg, 32'h80000000, 192'd0, 32'h00000100};
            default: blkData = '0;
        endcase
    end

    assign found      = found_reg;
    assign foundNonce = found_nonce_reg;
    assign foundHash  = found_hash_reg;
    assign hashCount  = hash_count_reg;
    assign timeoutErr = timeout_err_reg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg       <= IDLE;
            header_reg      <= '0;
            target_reg      <= '0;
            nonce_reg       <= '0;
            nonce_end_reg   <= '0;
            h1_reg          <= '0;
            h2_reg          <= '0;
            found_reg       <= 1'b0;
            found_nonce_reg <= '0;
            found_hash_reg  <= '0;
            hash_count_reg  <= '0;
            timeout_err_reg <= 1'b0;
            tmo_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            header_reg      <= header_next;
            target_reg      <= target_next;
            nonce_reg       <= nonce_next;
            nonce_end_reg   <= nonce_end_next;
            h1_reg          <= h1_next;
            h2_reg          <= h2_next;
            found_reg       <= found_next;
            found_nonce_reg <= found_nonce_next;
            found_hash_reg  <= found_hash_next;
            hash_count_reg  <= hash_count_next;
            timeout_err_reg <= timeout_err_next;
            tmo_cnt_reg     <= tmo_cnt_next;
        end
    end
endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Bench for sha256d_nonce_scheduler: a randomised Hasher model plus a job-level reference
// that predicts every block, the nonce walk, the hit decision and the final counts.
`timescale 1ns/1ps
module tb_sha256d_nonce_scheduler;
    localparam int W = 520;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstN, abort, start_a, start_b, sel;
    logic [639:0] header;
    logic [255:0] target;
    logic [31:0]  nonce_start, nonce_end;
    logic         blk_ready, hash_valid;
    logic [255:0] hash;

    logic         a_blk_valid, a_blk_first, a_blk_last, a_hash_ready, a_busy, a_done, a_found, a_timeout_err;
    logic [511:0] a_blk_data;
    logic [31:0]  a_found_nonce, a_hash_count;
    logic [255:0] a_found_hash;
    logic         b_blk_valid, b_blk_first, b_blk_last, b_hash_ready, b_busy, b_done, b_found, b_timeout_err;
    logic [511:0] b_blk_data;
    logic [31:0]  b_found_nonce, b_hash_count;
    logic [255:0] b_found_hash;

    // instance a steps by 1, instance b by 2; sel picks which one the Hasher model talks to
    sha256d_nonce_scheduler #(.NONCE_STEP(32'd1), .TIMEOUT_CYCLES(64)) dut_a (
        .clk(clk), .rstN(rstN), .start(start_a), .abort(abort), .header(header), .target(target),
        .nonceStart(nonce_start), .nonceEnd(nonce_end), .blkValid(a_blk_valid), .blkReady(blk_ready),
        .blkFirst(a_blk_first), .blkLast(a_blk_last), .blkData(a_blk_data), .hashValid(hash_valid),
        .hashReady(a_hash_ready), .hash(hash), .busy(a_busy), .done(a_done), .found(a_found),
        .foundNonce(a_found_nonce), .foundHash(a_found_hash), .hashCount(a_hash_count),
        .timeoutErr(a_timeout_err));
    sha256d_nonce_scheduler #(.NONCE_STEP(32'd2), .TIMEOUT_CYCLES(64)) dut_b (
        .clk(clk), .rstN(rstN), .start(start_b), .abort(abort), .header(header), .target(target),
        .nonceStart(nonce_start), .nonceEnd(nonce_end), .blkValid(b_blk_valid), .blkReady(blk_ready),
        .blkFirst(b_blk_first), .blkLast(b_blk_last), .blkData(b_blk_data), .hashValid(hash_valid),
        .hashReady(b_hash_ready), .hash(hash), .busy(b_busy), .done(b_done), .found(b_found),
        .foundNonce(b_found_nonce), .foundHash(b_found_hash), .hashCount(b_hash_count),
        .timeoutErr(b_timeout_err));

    logic         blk_valid, blk_first, blk_last, hash_ready, busy, done, found, timeout_err;
    logic [511:0] blk_data;
    logic [31:0]  found_nonce, hash_count;
    logic [255:0] found_hash;
    assign blk_valid   = sel ? b_blk_valid   : a_blk_valid;
    assign blk_first   = sel ? b_blk_first   : a_blk_first;
    assign blk_last    = sel ? b_blk_last    : a_blk_last;
    assign blk_data    = sel ? b_blk_data    : a_blk_data;
    assign hash_ready  = sel ? b_hash_ready  : a_hash_ready;
    assign busy        = sel ? b_busy        : a_busy;
    assign done        = sel ? b_done        : a_done;
    assign found       = sel ? b_found       : a_found;
    assign found_nonce = sel ? b_found_nonce : a_found_nonce;
    assign found_hash  = sel ? b_found_hash  : a_found_hash;
    assign hash_count  = sel ? b_hash_count  : a_hash_count;
    assign timeout_err = sel ? b_timeout_err : a_timeout_err;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Hasher model knobs and state
    bit           stall_req, no_valid, pending;
    int           delay_cfg, stall_cnt, delay_cnt, pending_kind, send2_wait;
    logic [255:0] pend_digest;
    logic [511:0] last_b2, last_b3;

    // job reference
    logic [639:0] t_hdr;
    logic [255:0] t_target, t_h1, t_fhash;
    logic [31:0]  t_ne, t_nonce, t_fnonce;
    int           t_step, t_phase, t_eval, t_xfers;
    bit           t_found, t_done;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [639:0] rand_hdr();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // block the spec says should appear at position ph of the current nonce: {first, last, data}
    function automatic logic [513:0] exp_block(input int ph);
        if (ph == 0) return {1'b1, 1'b0, t_hdr[639:128]};
        if (ph == 1) return {1'b0, 1'b1, t_hdr[127:32], t_nonce, 32'h80000000, 320'd0, 32'h00000280};
        return {1'b1, 1'b1, t_h1, 32'h80000000, 192'd0, 32'h00000100};
    endfunction

    initial begin
        bit           s_xfer, s_hs, s_first, s_last, p_hold;
        logic [511:0] s_data;
        logic [255:0] s_hash;
        logic [513:0] p_blk;
        longint       nxt;
        blk_ready = 1'b0; hash_valid = 1'b0; hash = '0; pending = 0; delay_cnt = 0;
        stall_cnt = 0; p_hold = 0; p_blk = '0; last_b2 = '0; last_b3 = '0; send2_wait = 0;
        pending_kind = 0;
        forever begin
            @(negedge clk);
            if (rstN) begin
                if (blk_valid || hash_ready)
                    check("blk_hready_excl", W'(blk_valid & hash_ready), W'(1'b0));
                if (p_hold)
                    check("blk_hold", W'({blk_valid, blk_first, blk_last, blk_data}), W'({1'b1, p_blk}));
                if (blk_valid && blk_last && !blk_first && !blk_ready) send2_wait++;
                s_xfer  = blk_valid & blk_ready;
                s_hs    = hash_valid & hash_ready;
                s_first = blk_first;
                s_last  = blk_last;
                s_data  = blk_data;
                s_hash  = hash;
                p_hold  = blk_valid & ~blk_ready & ~abort;
                p_blk   = {blk_first, blk_last, blk_data};
            end else begin
                s_xfer = 0; s_hs = 0; p_hold = 0;
            end
            @(posedge clk);
            #1;
            if (!rstN) begin
                pending = 0; hash_valid = 1'b0; blk_ready = 1'b0; stall_cnt = 0;
            end else begin
                if (s_hs) begin
                    pending = 0;
                    if (pending_kind == 1) begin
                        t_h1 = s_hash;
                    end else if (!t_done) begin
                        t_eval++;
                        t_phase = 0;
                        if (s_hash <= t_target) begin
                            t_found = 1; t_fnonce = t_nonce; t_fhash = s_hash; t_done = 1;
                        end else begin
                            nxt = longint'(t_nonce) + longint'(t_step);
                            if (nxt > longint'(t_ne)) t_done = 1;
                            else                       t_nonce = nxt[31:0];
                        end
                    end
                end
                if (pending && delay_cnt > 0) delay_cnt--;
                if (s_xfer) begin
                    check("blk", W'({s_first, s_last, s_data}), W'(exp_block(t_phase)));
                    t_phase++;
                    t_xfers++;
                    if (s_last && !s_first) last_b2 = s_data;
                    if (s_last && s_first)  last_b3 = s_data;
                    if (s_last) begin
                        pending      = 1;
                        pending_kind = s_first ? 2 : 1;
                        delay_cnt    = (delay_cfg >= 0) ? delay_cfg : int'($urandom_range(0, 3));
                        pend_digest  = rand256();
                    end
                end
                hash_valid = pending && (delay_cnt == 0) && !no_valid;
                hash       = pend_digest;
                if (stall_req && blk_valid && blk_last && !blk_first) begin
                    stall_cnt = 20; stall_req = 0;
                end
                if (stall_cnt > 0) begin
                    blk_ready = 1'b0; stall_cnt--;
                end else begin
                    blk_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, W'({blk_valid, blk_first, blk_last, hash_ready, busy, done, found,
                                  timeout_err, found_nonce, hash_count}), W'(0));
        check({tag, "_fhash"}, W'(found_hash), W'(0));
        check({tag, "_bdata"}, W'(blk_data), W'(0));
    endtask

    task automatic run_job(input bit s, input logic [639:0] h, input logic [255:0] tg,
                           input logic [31:0] ns, input logic [31:0] ne, input bit with_abort);
        sel = s; header = h; target = tg; nonce_start = ns; nonce_end = ne;
        t_hdr = h; t_target = tg; t_ne = ne; t_nonce = ns; t_step = s ? 2 : 1;
        t_phase = 0; t_eval = 0; t_xfers = 0; t_found = 0; t_done = 0; t_h1 = '0;
        t_fnonce = '0; t_fhash = '0;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        abort = with_abort;
        tick();
        start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        check("busy_after_start", W'(busy), W'(1'b1));
    endtask

    task automatic wait_finish(input string tag);
        for (int i = 0; i < 4000 && !done; i++) tick();
        check({tag, "_done"}, W'(done), W'(1'b1));
        check({tag, "_found"}, W'(found), W'(t_found));
        if (t_found) begin
            check({tag, "_fnonce"}, W'(found_nonce), W'(t_fnonce));
            check({tag, "_fhash"}, W'(found_hash), W'(t_fhash));
        end
        check({tag, "_count"}, W'(hash_count), W'(t_eval));
        check({tag, "_xfers"}, W'(t_xfers), W'(3 * t_eval));
        check({tag, "_ref_end"}, W'(t_done), W'(1'b1));
        check({tag, "_tmo"}, W'(timeout_err), W'(1'b0));
    endtask

    task automatic end_job(input string tag);
        tick();
        check({tag, "_idle"}, W'({busy, done}), W'(0));
    endtask

    initial begin
        int           n, drops;
        logic [255:0] tg;
        logic [31:0]  ns, ne;
        rstN = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; sel = 1'b0;
        header = '0; target = '0; nonce_start = '0; nonce_end = '0;
        stall_req = 0; no_valid = 0; delay_cfg = -1;
        tick(); tick();
        check_zero("reset");
        rstN = 1'b1;
        tick();
        check_zero("idle");

        // hit on the only nonce
        run_job(0, rand_hdr(), '1, 32'd5, 32'd5, 0);
        wait_finish("single");
        check("single_found_k", W'(found), W'(1'b1));
        check("single_fnonce_k", W'(found_nonce), W'(32'd5));
        check("single_count_k", W'(hash_count), W'(32'd1));
        check("b2_word3", W'(last_b2[415:384]), W'(32'd5));
        check("b2_word15", W'(last_b2[31:0]), W'(32'h280));
        check("b3_word8", W'(last_b3[255:224]), W'(32'h80000000));
        check("b3_word15", W'(last_b3[31:0]), W'(32'h100));
        end_job("single");

        // no hit over 10..12
        run_job(0, rand_hdr(), '0, 32'd10, 32'd12, 0);
        wait_finish("range");
        check("range_count_k", W'(hash_count), W'(32'd3));
        check("range_found_k", W'(found), W'(1'b0));
        end_job("range");

        // step 2 at the top of the nonce space must not wrap
        run_job(1, rand_hdr(), '0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0);
        wait_finish("wrap");
        check("wrap_count_k", W'(hash_count), W'(32'd1));
        end_job("wrap");

        // 20-cycle blkReady stall on block 2
        send2_wait = 0; stall_req = 1;
        run_job(0, rand_hdr(), rand256(), 32'd7, 32'd7, 0);
        wait_finish("stall");
        check("stall_len", W'(send2_wait >= 20), W'(1'b1));
        end_job("stall");
        stall_req = 0;

        // abort in WAIT1 with the digest 30 cycles away: must drain
        delay_cfg = 30;
        run_job(0, rand_hdr(), '0, 32'd20, 32'd25, 0);
        for (int i = 0; i < 300 && !hash_ready; i++) tick();
        check("abort_reach", W'(hash_ready), W'(1'b1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drops = 0; n = 0;
        while (!done && n < 500) begin
            if (!hash_ready) drops++;
            n++;
            tick();
        end
        check("abort_done", W'(done), W'(1'b1));
        check("abort_found", W'(found), W'(1'b0));
        check("abort_hready_held", W'(drops), W'(0));
        check("abort_consumed", W'(pending), W'(1'b0));
        check("abort_no_more_blks", W'(t_xfers), W'(2));
        check("abort_waited", W'(n >= 25), W'(1'b1));
        end_job("abort");
        delay_cfg = -1;
        run_job(0, rand_hdr(), '1, 32'd40, 32'd44, 0);
        wait_finish("post_abort");
        end_job("post_abort");

        // abort in SEND1: nothing outstanding, ends at once
        run_job(0, rand_hdr(), '0, 32'd1, 32'd9, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort1_blk", W'(blk_valid), W'(1'b0));
        check("abort1_done", W'({done, found}), W'(2'b10));
        end_job("abort1");

        // start together with abort in IDLE: start wins
        run_job(1, rand_hdr(), '0, 32'd100, 32'd103, 1);
        wait_finish("start_abort");
        end_job("start_abort");

        // Hasher never answers: timeout after 64 cycles in WAIT1
        no_valid = 1;
        run_job(1, rand_hdr(), '1, 32'd3, 32'd3, 0);
        for (int i = 0; i < 300 && !hash_ready; i++) tick();
        n = 0;
        while (!done && n < 300) begin
            if (hash_ready) n++;
            tick();
        end
        check("tmo_cycles", W'(n), W'(64));
        check("tmo_flags", W'({done, timeout_err, found}), W'(3'b110));
        check("tmo_count", W'(hash_count), W'(0));
        end_job("tmo");
        no_valid = 0;

        // randomised jobs on both instances
        for (int j = 0; j < 12; j++) begin
            tg = '1;
            tg[255:248] = 8'($urandom_range(0, 255));
            ns = $urandom();
            if (j % 4 == 3) ns = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
            ne = ns + 32'($urandom_range(0, 4));
            if (j % 5 == 4) ne = ns - 32'd1;
            run_job(1'($urandom_range(0, 1)), rand_hdr(), tg, ns, ne, 0);
            wait_finish($sformatf("rnd%0d", j));
            end_job($sformatf("rnd%0d", j));
        end

        // reset in the middle of SEND3 of the third nonce
        run_job(0, rand_hdr(), '0, 32'd0, 32'd9, 0);
        for (int i = 0; i < 2000 && !(hash_count >= 32'd2 && blk_valid && blk_first && blk_last); i++) tick();
        check("rst_reach", W'(hash_count >= 32'd2 && blk_valid && blk_first && blk_last), W'(1'b1));
        rstN = 1'b0;
        #1;
        check_zero("midrst");
        tick(); tick();
        check_zero("midrst_hold");
        rstN = 1'b1;
        tick();
        run_job(0, rand_hdr(), rand256(), 32'd50, 32'd52, 0);
        wait_finish("post_rst");
        end_job("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
